// File: rtl/gb_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : gb_lcd_capture
// Purpose  : Samples the asynchronous Game Boy LCD bus and emits one linear
//            framebuffer write per accepted pixel, with line/frame checking.
// Revision : 1.0 - initial release
// ============================================================================
module gb_lcd_capture #(
  parameter int H_PIX       = 160,
  parameter int V_LINES     = 144,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        idata,
  input  logic              iclk,
  input  logic              ihsync,
  input  logic              ivsync,
  output logic [ADDR_W-1:0] wraddress,
  output logic [1:0]        wdata,
  output logic              wren,
  output logic              frame_done,
  output logic              line_err,
  output logic              frame_err,
  output logic              locked
);

  localparam int COL_W = $clog2(H_PIX + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  localparam logic [COL_W-1:0]  c_h_pix     = COL_W'(H_PIX);
  localparam logic [COL_W-1:0]  c_last_col  = COL_W'(H_PIX - 1);
  localparam logic [ROW_W-1:0]  c_v_lines   = ROW_W'(V_LINES);
  localparam logic [ROW_W-1:0]  c_last_row  = ROW_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] c_row_step  = ADDR_W'(H_PIX);

  logic [SYNC_STAGES-1:0]      r_clk_sync;
  logic [SYNC_STAGES-1:0]      r_hs_sync;
  logic [SYNC_STAGES-1:0]      r_vs_sync;
  logic [SYNC_STAGES-1:0][1:0] r_data_sync;
  logic                        r_clk_prev;
  logic                        r_hs_prev;
  logic                        r_vs_prev;

  logic [1:0]        r_state;
  logic [ROW_W-1:0]  r_row;
  logic [COL_W-1:0]  r_col;
  logic [ADDR_W-1:0] r_base;
  logic              r_ovf;
  logic              r_frame_bad;
  logic              r_wren;
  logic [ADDR_W-1:0] r_wraddress;
  logic [1:0]        r_wdata;
  logic              r_frame_done;
  logic              r_line_err;
  logic              r_frame_err;
  logic              r_locked;

  logic       w_pix_edge;
  logic       w_hs_edge;
  logic       w_vs_edge;
  logic [1:0] w_pix_data;

  // Data shares the pixel-clock chain depth so it arrives with its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync  <= '0;
      r_hs_sync   <= '0;
      r_vs_sync   <= '0;
      r_data_sync <= '0;
      r_clk_prev  <= 1'b0;
      r_hs_prev   <= 1'b0;
      r_vs_prev   <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], iclk};
      r_hs_sync   <= {r_hs_sync[SYNC_STAGES-2:0], ihsync};
      r_vs_sync   <= {r_vs_sync[SYNC_STAGES-2:0], ivsync};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], idata};
      r_clk_prev  <= r_clk_sync[SYNC_STAGES-1];
      r_hs_prev   <= r_hs_sync[SYNC_STAGES-1];
      r_vs_prev   <= r_vs_sync[SYNC_STAGES-1];
    end
  end

  assign w_pix_edge = r_clk_sync[SYNC_STAGES-1] & ~r_clk_prev;
  assign w_hs_edge  = r_hs_sync[SYNC_STAGES-1] & ~r_hs_prev;
  assign w_vs_edge  = r_vs_sync[SYNC_STAGES-1] & ~r_vs_prev;
  assign w_pix_data = r_data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_base       <= '0;
      r_ovf        <= 1'b0;
      r_frame_bad  <= 1'b0;
      r_wren       <= 1'b0;
      r_wraddress  <= '0;
      r_wdata      <= '0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_wren       <= 1'b0;
      r_frame_done <= 1'b0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;

      // vsync outranks hsync, which outranks a pixel in the same cycle.
      if (w_vs_edge) begin
        if (r_state == S_CAPTURE) begin
          r_frame_err <= 1'b1;
          r_locked    <= 1'b0;
        end
        r_state     <= S_CAPTURE;
        r_row       <= '0;
        r_col       <= '0;
        r_base      <= '0;
        r_ovf       <= 1'b0;
        r_frame_bad <= 1'b0;
      end else if (r_state == S_CAPTURE) begin
        if (w_hs_edge) begin
          // col==0 means the line has not started yet (hsync right after vsync).
          if (r_col != '0) begin
            r_row  <= r_row + ROW_W'(1);
            r_col  <= '0;
            r_base <= r_base + c_row_step;
            r_ovf  <= 1'b0;
            if ((r_col != c_h_pix) || r_ovf) begin
              r_line_err  <= 1'b1;
              r_locked    <= 1'b0;
              r_frame_bad <= 1'b1;
            end
          end
        end else if (w_pix_edge) begin
          if ((r_col < c_h_pix) && (r_row < c_v_lines)) begin
            r_wren      <= 1'b1;
            r_wraddress <= r_base + ADDR_W'(r_col);
            r_wdata     <= w_pix_data;
            r_col       <= r_col + COL_W'(1);
            if ((r_col == c_last_col) && (r_row == c_last_row)) begin
              r_frame_done <= 1'b1;
              r_locked     <= ~r_frame_bad;
              r_state      <= S_DONE;
            end
          end else if (r_col == c_h_pix) begin
            r_ovf <= 1'b1;
          end
        end
      end
    end
  end

  assign wren       = r_wren;
  assign wraddress  = r_wraddress;
  assign wdata      = r_wdata;
  assign frame_done = r_frame_done;
  assign line_err   = r_line_err;
  assign frame_err  = r_frame_err;
  assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_gb_lcd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_gb_lcd_capture
// Purpose  : Directed scoreboard bench for gb_lcd_capture (narrow 16-pixel
//            lines keep full 144-line frames short).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gb_lcd_capture;

  localparam int H  = 16;
  localparam int V  = 144;
  localparam int SS = 2;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    idata;
  logic          iclk;
  logic          ihsync;
  logic          ivsync;
  logic [AW-1:0] wraddress;
  logic [1:0]    wdata;
  logic          wren;
  logic          frame_done;
  logic          line_err;
  logic          frame_err;
  logic          locked;

  always #5 clk = ~clk;

  gb_lcd_capture #(
    .H_PIX(H), .V_LINES(V), .SYNC_STAGES(SS), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .idata(idata), .iclk(iclk),
    .ihsync(ihsync), .ivsync(ivsync), .wraddress(wraddress), .wdata(wdata),
    .wren(wren), .frame_done(frame_done), .line_err(line_err),
    .frame_err(frame_err), .locked(locked)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    data;
    logic          fd;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_assert = 0;
  int  n_fail   = 0;
  int  n_wr = 0, n_le = 0, n_fe = 0, n_fd = 0;
  int  s_wr, s_le, s_fe, s_fd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every write and counts pulses.
  always @(negedge clk) begin
    if (line_err === 1'b1)  n_le++;
    if (frame_err === 1'b1) n_fe++;
    if (frame_done === 1'b1) n_fd++;
    if (wren === 1'b1) begin
      n_wr++;
      if (sb.size() == 0) begin
        check("unexpected_write_addr", 32'(wraddress), 32'hFFFF_FFFF);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(wraddress), 32'(mon_e.addr));
        check("wr_data", 32'(wdata), 32'(mon_e.data));
        check("wr_frame_done", 32'(frame_done), 32'(mon_e.fd));
      end
    end else if (frame_done === 1'b1) begin
      check("frame_done_without_wren", 32'(frame_done), 32'd0);
    end
  end

  task automatic push(input int addr, input logic [1:0] d, input bit fd);
    wr_t e;
    e.addr = AW'(addr);
    e.data = d;
    e.fd   = fd;
    sb.push_back(e);
  endtask

  task automatic send_pixel(input logic [1:0] d, input bit exp, input int addr, input bit fd);
    @(negedge clk);
    iclk  = 1'b1;
    idata = d;
    if (exp) push(addr, d, fd);
    @(negedge clk);
    iclk = 1'b0;
  endtask

  task automatic send_hsync();
    @(negedge clk); ihsync = 1'b1;
    @(negedge clk); ihsync = 1'b0;
  endtask

  task automatic send_vsync();
    @(negedge clk); ivsync = 1'b1;
    @(negedge clk); ivsync = 1'b0;
  endtask

  // Columns c0..npix-1 of a row; columns at or beyond H must not be written.
  task automatic send_line(input int row, input int c0, input int npix);
    for (int c = c0; c < npix; c++)
      send_pixel(2'(c), (c < H), row * H + c, (row == V - 1) && (c == H - 1));
  endtask

  task automatic send_rows(input int r0, input int r1);
    for (int r = r0; r <= r1; r++) begin
      send_line(r, 0, H);
      if (r != V - 1) send_hsync();
    end
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  task automatic snap();
    s_wr = n_wr; s_le = n_le; s_fe = n_fe; s_fd = n_fd;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; iclk = 1'b0; ihsync = 1'b0; ivsync = 1'b0; idata = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_wraddress", 32'(wraddress), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    rst_n = 1'b1;

    // Pixels with no vsync: IDLE must not write.
    snap();
    for (int i = 0; i < H; i++) send_pixel(2'(i), 1'b0, 0, 1'b0);
    send_hsync();
    drain();
    check("idle_no_write", 32'(n_wr - s_wr), 32'd0);
    check("idle_locked", 32'(locked), 32'd0);

    // Frame 1: clean, first pixel also checks write latency.
    snap();
    send_vsync();
    send_hsync();
    @(negedge clk); iclk = 1'b1; idata = 2'd0; push(0, 2'd0, 1'b0);
    @(negedge clk); iclk = 1'b0;
    @(negedge clk); check("wren_before_latency", 32'(wren), 32'd0);
    @(negedge clk); check("wren_at_latency", 32'(wren), 32'd1);
    send_line(0, 1, H);
    send_hsync();
    send_rows(1, V - 1);
    drain();
    check("f1_frame_done_count", 32'(n_fd - s_fd), 32'd1);
    check("f1_line_err_count", 32'(n_le - s_le), 32'd0);
    check("f1_frame_err_count", 32'(n_fe - s_fe), 32'd0);
    check("f1_locked", 32'(locked), 32'd1);
    check("f1_sb_empty", 32'(sb.size()), 32'd0);

    // DONE ignores pixels and hsync.
    snap();
    for (int i = 0; i < 3; i++) send_pixel(2'(i), 1'b0, 0, 1'b0);
    send_hsync();
    drain();
    check("done_no_write", 32'(n_wr - s_wr), 32'd0);
    check("done_locked_held", 32'(locked), 32'd1);

    // Frame 2: short line 5, long line 6, aborted by vsync after 100 lines.
    snap();
    send_vsync();
    send_hsync();
    drain();
    check("vsync_from_done_no_err", 32'(n_fe - s_fe), 32'd0);
    send_rows(0, 4);
    send_line(5, 0, H - 2);
    send_hsync();
    drain();
    check("short_line_err", 32'(n_le - s_le), 32'd1);
    check("short_line_unlock", 32'(locked), 32'd0);
    send_line(6, 0, H + 2);
    send_hsync();
    drain();
    check("long_line_err", 32'(n_le - s_le), 32'd2);
    send_rows(7, 99);
    drain();
    check("clean_lines_no_err", 32'(n_le - s_le), 32'd2);
    send_vsync();
    drain();
    check("early_vsync_frame_err", 32'(n_fe - s_fe), 32'd1);
    check("early_vsync_locked", 32'(locked), 32'd0);
    check("f2_sb_empty", 32'(sb.size()), 32'd0);

    // Frame 3: clean recapture from row 0 relocks.
    snap();
    send_hsync();
    send_rows(0, V - 1);
    drain();
    check("f3_frame_done_count", 32'(n_fd - s_fd), 32'd1);
    check("f3_line_err_count", 32'(n_le - s_le), 32'd0);
    check("f3_frame_err_count", 32'(n_fe - s_fe), 32'd0);
    check("f3_locked", 32'(locked), 32'd1);
    check("f3_sb_empty", 32'(sb.size()), 32'd0);

    // Pixel, hsync and vsync edges in one sampled cycle: vsync only.
    send_vsync();
    send_hsync();
    send_line(0, 0, 3);
    drain();
    snap();
    @(negedge clk); iclk = 1'b1; ihsync = 1'b1; ivsync = 1'b1; idata = 2'd3;
    @(negedge clk); iclk = 1'b0; ihsync = 1'b0; ivsync = 1'b0;
    drain();
    check("simul_frame_err", 32'(n_fe - s_fe), 32'd1);
    check("simul_no_line_err", 32'(n_le - s_le), 32'd0);
    check("simul_no_write", 32'(n_wr - s_wr), 32'd0);
    send_pixel(2'd2, 1'b1, 0, 1'b0);
    drain();
    check("simul_restart_sb_empty", 32'(sb.size()), 32'd0);

    // Reset mid-line: outputs clear at once, no writes until vsync.
    send_line(0, 1, 4);
    drain();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_wren", 32'(wren), 32'd0);
    check("midrst_wraddress", 32'(wraddress), 32'd0);
    check("midrst_wdata", 32'(wdata), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    for (int i = 0; i < 5; i++) send_pixel(2'(i), 1'b0, 0, 1'b0);
    send_hsync();
    drain();
    check("midrst_no_write", 32'(n_wr - s_wr), 32'd0);
    check("midrst_no_line_err", 32'(n_le - s_le), 32'd0);
    check("midrst_no_frame_err", 32'(n_fe - s_fe), 32'd0);
    send_vsync();
    send_pixel(2'd1, 1'b1, 0, 1'b0);
    drain();
    check("post_rst_capture_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gb_lcd_capture.md
Name: gb_lcd_capture

Overview:
- Upstream input stage of the Game Boy-to-VGA path. Samples the asynchronous Game Boy LCD bus (idata, iclk, ihsync, ivsync) in the system clock domain.
- Tracks row and column of each incoming pixel and emits one framebuffer write per accepted pixel (wraddress, wdata, wren). The output address is row*H_PIX + col, the 160x144 linear layout that the VGA scan-out reader consumes.
- Adds line/frame integrity checking and a lock indicator, so frames are captured only from a known-good sync position.

Parameters:
- H_PIX, 160, visible pixels per LCD line
- V_LINES, 144, visible lines per LCD frame
- SYNC_STAGES, 2, flip-flop stages on each LCD input (minimum 2)
- ADDR_W, 15, framebuffer write address width

Ports:
- clk  in  1  system clock (pll output), all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- idata  in  2  LCD pixel data, asynchronous
- iclk  in  1  LCD pixel clock, asynchronous; pixel taken on its rising edge
- ihsync  in  1  LCD line sync, asynchronous; rising edge starts a line
- ivsync  in  1  LCD frame sync, asynchronous; rising edge starts a frame
- wraddress  out  ADDR_W  framebuffer write address
- wdata  out  2  framebuffer write data
- wren  out  1  framebuffer write strobe, one cycle per pixel
- frame_done  out  1  1-cycle pulse: last pixel of a frame written
- line_err  out  1  1-cycle pulse: line ended with column count != H_PIX
- frame_err  out  1  1-cycle pulse: vsync arrived before frame completed
- locked  out  1  level: last frame completed without error

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, row=0, col=0, sync chains and edge registers cleared.
- Sync and edge detection:
  - idata, iclk, ihsync and ivsync each pass through SYNC_STAGES flops. idata uses the same chain depth as iclk, so data and clock stay aligned.
  - A rising edge is detected as sync_out & ~prev.
- Write latency: wren, wraddress and wdata are registered. wren rises SYNC_STAGES+1 clk edges after the iclk rising edge is sampled at the pin. Address and data are valid in the same cycle as wren.
- Edge priority within one cycle: vsync, then hsync, then pixel.
- States:
  - IDLE: no writes. vsync edge -> CAPTURE, row=0, col=0.
  - CAPTURE:
    - pixel edge with col<H_PIX and row<V_LINES: write addr row*H_PIX+col with the sampled idata, then col+1.
    - pixel edge with col==H_PIX: pixel dropped, overflow flag set.
    - hsync edge with col==0: no row change (covers the first line, where hsync follows vsync).
    - hsync edge with col!=0: row+1 and col=0. If col!=H_PIX or the overflow flag is set, pulse line_err and clear locked. Overflow flag is cleared.
    - H_PIX-th pixel write of row V_LINES-1: pulse frame_done in the same cycle as that wren, then -> DONE.
    - vsync edge: pulse frame_err, clear locked, restart at row=0, col=0 and stay in CAPTURE.
  - DONE: pixels and hsync ignored (no wren). vsync edge -> CAPTURE, row=0, col=0, no error.
- locked:
  - Set on frame_done if no line_err occurred in that frame (per-frame error flag, cleared at each vsync edge).
  - Cleared by line_err, frame_err or reset.
- Arithmetic and bounds:
  - col width is ceil(log2(H_PIX+1)); row width is ceil(log2(V_LINES+1)).
  - Address is computed with a row-base accumulator (base += H_PIX on each row advance), not a multiplier.
  - Maximum address is H_PIX*V_LINES-1 = 23039, which fits in 15 bits.
- Vsync with no line: vsync in the same cycle as a pixel edge drops that pixel.
- Reset mid-frame: returns to IDLE; no writes until the next vsync edge. A partial frame produces no error pulse.
- Pulse outputs (frame_done, line_err, frame_err) are exactly one clk wide and registered.

Test Plan:
- Reset, then 160 iclk pulses with no vsync -> wren stays 0, state IDLE, locked=0.
- vsync, then 144 lines of 160 pixels with data = col[1:0] -> 23040 writes:
  - first write addr 0 data 0; write at row 1 col 0 has addr 160.
  - last write addr 23039, with frame_done high in the same cycle.
  - locked=1 afterwards.
- Line 5 carries 158 pixels -> line_err pulses at line 6 hsync, locked=0, and the next line starts at addr 6*160=960.
- Line carries 162 pixels -> the last two pixels produce no wren, line_err pulses at the next hsync, and there is no write to addr row*160+160.
- vsync after 100 complete lines -> frame_err pulses and the next pixel writes addr 0. A further clean frame -> frame_done and locked=1.
- iclk, hsync and vsync edges in the same sampled cycle -> vsync handled only and no wren. Separately, rst_n asserted mid-line -> all outputs 0 immediately, and no wren until a new vsync.
